// File: rtl/fp_add_arbiter_pkg.sv
// Shared constants and types for the two-requester floating-point adder arbiter.
package fp_add_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int ADD_LAT_DEF = 1;
  localparam int FP_W        = 32;
  localparam int EXP_W       = 8;
  localparam int FRAC_W      = 25;
  // Wide enough for the largest legal adder latency (15).
  localparam int WCNT_W      = 4;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_res_t;

endpackage

// File: rtl/fp_add_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, on contention the
// requester that was not granted last time wins.
module rr_arbiter2
  import fp_add_arbiter_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic gnt0,
  output logic gnt1
);

  assign gnt0 = valid0 && (!valid1 || last_grant);
  assign gnt1 = valid1 && (!valid0 || !last_grant);

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one external floating-point adder between two requesters, one
// operation in flight, returning the raw adder result on a tagged channel.
module fp_add_arbiter
  import fp_add_arbiter_pkg::*;
#(
  parameter int ADD_LAT = ADD_LAT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [FP_W-1:0]   req0_a,
  input  logic [FP_W-1:0]   req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [FP_W-1:0]   req1_a,
  input  logic [FP_W-1:0]   req1_b,
  output logic [FP_W-1:0]   adder_in1,
  output logic [FP_W-1:0]   adder_in2,
  input  logic              adder_sign,
  input  logic [EXP_W-1:0]  adder_exp,
  input  logic [FRAC_W-1:0] adder_frac,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic              resp_sign,
  output logic [EXP_W-1:0]  resp_exp,
  output logic [FRAC_W-1:0] resp_frac,
  output logic              busy,
  output logic [CNT_W-1:0]  done0_cnt,
  output logic [CNT_W-1:0]  done1_cnt
);

  logic [1:0]        state;
  logic              last_grant;
  logic              owner;
  logic [WCNT_W-1:0] wait_cnt;
  logic              gnt0;
  logic              gnt1;
  fp_res_t           res_q;

  rr_arbiter2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .gnt0       (gnt0),
    .gnt1       (gnt1)
  );

  assign req0_ready = (state == ST_IDLE) && gnt0;
  assign req1_ready = (state == ST_IDLE) && gnt1;
  assign busy       = (state != ST_IDLE);
  assign resp_sign  = res_q.sign;
  assign resp_exp   = res_q.exp;
  assign resp_frac  = res_q.frac;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      wait_cnt   <= '0;
      adder_in1  <= '0;
      adder_in2  <= '0;
      res_q      <= '0;
      resp_id    <= 1'b0;
      resp_valid <= 1'b0;
      done0_cnt  <= '0;
      done1_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0_ready) begin
            adder_in1  <= req0_a;
            adder_in2  <= req0_b;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            wait_cnt   <= WCNT_W'(ADD_LAT);
            state      <= ST_WAIT;
          end else if (req1_ready) begin
            adder_in1  <= req1_a;
            adder_in2  <= req1_b;
            owner      <= 1'b1;
            last_grant <= 1'b1;
            wait_cnt   <= WCNT_W'(ADD_LAT);
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Operands stay on adder_in*; the adder output is sampled on the
          // last counted edge.
          wait_cnt <= wait_cnt - WCNT_W'(1);
          if (wait_cnt == WCNT_W'(1)) begin
            res_q      <= {adder_sign, adder_exp, adder_frac};
            resp_id    <= owner;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            if (owner) done1_cnt <= done1_cnt + CNT_W'(1);
            else       done0_cnt <= done0_cnt + CNT_W'(1);
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: an ADD_LAT=1 and an ADD_LAT=3 instance share one
// stimulus stream and are each compared every cycle against a transaction model.
module tb_fp_add_arbiter;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        v0 = 1'b0, v1 = 1'b0, rr = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

  logic        rdy0 [2], rdy1 [2], rv [2], rid [2], rs [2], bsy [2], asgn [2];
  logic [31:0] ain1 [2], ain2 [2];
  logic [7:0]  rexp [2], aexp [2];
  logic [24:0] rfrac [2], afrac [2];
  logic [15:0] c0_a, c1_a;
  logic [3:0]  c0_b, c1_b;
  logic [15:0] cnt0 [2], cnt1 [2];
  logic [33:0] st_p1 = '0, st_p2 = '0;

  int n_chk = 0;
  int n_fail = 0;

  // Simplified adder: align the smaller magnitude, add or subtract the
  // 24-bit significands, keep the larger exponent and sign, no normalisation.
  function automatic logic [33:0] stub_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] big, sml;
    logic [7:0]  d;
    logic [24:0] mb, ms, f;
    if (x[30:0] >= y[30:0]) begin big = x; sml = y; end
    else begin big = y; sml = x; end
    d  = big[30:23] - sml[30:23];
    mb = {2'b01, big[22:0]};
    ms = {2'b01, sml[22:0]};
    ms = (d > 8'd24) ? 25'd0 : (ms >> d);
    f  = (big[31] == sml[31]) ? (mb + ms) : (mb - ms);
    return {big[31], big[30:23], f};
  endfunction

  task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s[%0d]: actual %0h required %0h at %0t", nm, inst, act, req, $time);
    end
  endtask

  fp_add_arbiter #(.ADD_LAT(LAT0), .CNT_W(16)) u_dut0 (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_ready(rdy0[0]), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(rdy1[0]), .req1_a(a1), .req1_b(b1),
    .adder_in1(ain1[0]), .adder_in2(ain2[0]),
    .adder_sign(asgn[0]), .adder_exp(aexp[0]), .adder_frac(afrac[0]),
    .resp_valid(rv[0]), .resp_ready(rr), .resp_id(rid[0]),
    .resp_sign(rs[0]), .resp_exp(rexp[0]), .resp_frac(rfrac[0]),
    .busy(bsy[0]), .done0_cnt(c0_a), .done1_cnt(c1_a)
  );

  fp_add_arbiter #(.ADD_LAT(LAT1), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_ready(rdy0[1]), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(rdy1[1]), .req1_a(a1), .req1_b(b1),
    .adder_in1(ain1[1]), .adder_in2(ain2[1]),
    .adder_sign(asgn[1]), .adder_exp(aexp[1]), .adder_frac(afrac[1]),
    .resp_valid(rv[1]), .resp_ready(rr), .resp_id(rid[1]),
    .resp_sign(rs[1]), .resp_exp(rexp[1]), .resp_frac(rfrac[1]),
    .busy(bsy[1]), .done0_cnt(c0_b), .done1_cnt(c1_b)
  );

  // Adder stubs: combinational for latency 1, two extra register stages for latency 3.
  assign {asgn[0], aexp[0], afrac[0]} = stub_add(ain1[0], ain2[0]);
  always @(posedge clk) begin
    st_p1 <= stub_add(ain1[1], ain2[1]);
    st_p2 <= st_p1;
  end
  assign {asgn[1], aexp[1], afrac[1]} = st_p2;

  assign cnt0[0] = c0_a;
  assign cnt1[0] = c1_a;
  assign cnt0[1] = {12'd0, c0_b};
  assign cnt1[1] = {12'd0, c1_b};

  // Transaction model per instance
  bit          m_busy [2];
  bit          m_last [2];
  bit          m_id [2];
  logic [31:0] m_a [2], m_b [2];
  logic [33:0] m_res [2];
  int          m_issue [2];
  int          m_cnt [2][2];
  int          lat [2] = '{LAT0, LAT1};
  int          cmask [2] = '{32'hFFFF, 32'hF};
  int          cyc = 0;

  always @(negedge clk) begin
    bit e0, e1, mrv, n;
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_busy[i] = 1'b0;
        m_last[i] = 1'b1;
        m_a[i] = '0;
        m_b[i] = '0;
        m_cnt[i][0] = 0;
        m_cnt[i][1] = 0;
        chk("rst_busy", i, bsy[i], 0);
        chk("rst_resp", i, {rv[i], rid[i], rs[i], rexp[i], rfrac[i]}, 0);
        chk("rst_adder_in", i, {ain1[i], ain2[i]}, 0);
        chk("rst_cnt", i, {cnt0[i], cnt1[i]}, 0);
      end else begin
        e0  = !m_busy[i] && v0 && (!v1 || m_last[i]);
        e1  = !m_busy[i] && v1 && (!v0 || !m_last[i]);
        mrv = m_busy[i] && (cyc >= m_issue[i] + lat[i]);
        chk("req0_ready", i, rdy0[i], e0);
        chk("req1_ready", i, rdy1[i], e1);
        chk("busy", i, bsy[i], m_busy[i]);
        chk("adder_in", i, {ain1[i], ain2[i]}, {m_a[i], m_b[i]});
        chk("done0_cnt", i, cnt0[i], m_cnt[i][0]);
        chk("done1_cnt", i, cnt1[i], m_cnt[i][1]);
        chk("resp_valid", i, rv[i], mrv);
        if (mrv)
          chk("resp_data", i, {rid[i], rs[i], rexp[i], rfrac[i]}, {m_id[i], m_res[i]});
        if (e0 || e1) begin
          n = e1;
          m_busy[i]  = 1'b1;
          m_last[i]  = n;
          m_id[i]    = n;
          m_a[i]     = n ? a1 : a0;
          m_b[i]     = n ? b1 : b0;
          m_res[i]   = stub_add(m_a[i], m_b[i]);
          m_issue[i] = cyc + 1;
        end else if (mrv && rr) begin
          m_cnt[i][m_id[i]] = (m_cnt[i][m_id[i]] + 1) & cmask[i];
          m_busy[i] = 1'b0;
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (!bsy[0] && !bsy[1]) ok = 1'b1;
    end
    chk({nm, "_idle_timeout"}, 0, ok, 1);
  endtask

  task automatic wait_grant0(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (rdy0[0] || rdy1[0]) ok = 1'b1;
    end
    chk({nm, "_grant_timeout"}, 0, ok, 1);
  endtask

  task automatic wait_rv0(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (rv[0]) ok = 1'b1;
    end
    chk({nm, "_resp_timeout"}, 0, ok, 1);
  endtask

  initial begin
    int order [4];
    int ng;
    logic [34:0] snap;

    chk("pin_1p1", 0, stub_add(32'h3F800000, 32'h3F800000), {1'b0, 8'h7F, 25'h1000000});
    chk("pin_2m1", 0, stub_add(32'h40000000, 32'hBF800000), {1'b0, 8'h80, 25'h0400000});
    chk("pin_1p5p05", 0, stub_add(32'h3FC00000, 32'h3F000000), {1'b0, 8'h7F, 25'h1000000});

    #1 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;

    // Lone requester 0: 1.0 + 1.0
    tick();
    rr = 1'b1; v0 = 1'b1; a0 = 32'h3F800000; b0 = 32'h3F800000;
    wait_grant0("t1");
    tick();
    v0 = 1'b0;
    wait_rv0("t1");
    chk("t1_adder_in", 0, {ain1[0], ain2[0]}, {32'h3F800000, 32'h3F800000});
    chk("t1_resp", 0, {rid[0], rs[0], rexp[0], rfrac[0]}, {1'b0, 1'b0, 8'h7F, 25'h1000000});
    wait_idle("t1");
    chk("t1_done0", 0, c0_a, 16'd1);

    // Lone requester 1: 2.0 + -1.0
    tick();
    v1 = 1'b1; a1 = 32'h40000000; b1 = 32'hBF800000;
    wait_grant0("t2");
    tick();
    v1 = 1'b0;
    wait_rv0("t2");
    chk("t2_resp", 0, {rid[0], rs[0], rexp[0], rfrac[0]}, {1'b1, 1'b0, 8'h80, 25'h0400000});
    wait_idle("t2");

    // Continuous contention: grants must alternate starting with requester 0
    tick();
    v0 = 1'b1; v1 = 1'b1;
    a0 = 32'h3F800000; b0 = 32'h40400000; a1 = 32'hC0A00000; b1 = 32'h3E800000;
    ng = 0;
    for (int k = 0; k < 100 && ng < 4; k++) begin
      @(negedge clk);
      if (rdy0[0]) begin order[ng] = 0; ng++; end
      else if (rdy1[0]) begin order[ng] = 1; ng++; end
    end
    tick();
    v0 = 1'b0; v1 = 1'b0;
    chk("t3_grants", 0, ng, 4);
    for (int k = 0; k < 4; k++) chk("t3_order", k, order[k], k % 2);
    wait_idle("t3");
    chk("t3_done0", 0, c0_a, 16'd3);
    chk("t3_done1", 0, c1_a, 16'd3);

    // Consumer backpressure for 5 cycles in RESP
    tick();
    rr = 1'b0; v0 = 1'b1; v1 = 1'b1; a0 = 32'h41200000; b0 = 32'hC1000000;
    wait_rv0("t4");
    snap = {rid[0], rs[0], rexp[0], rfrac[0]};
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("t4_stable", k, {rid[0], rs[0], rexp[0], rfrac[0]}, snap);
      chk("t4_no_ready", k, {rdy0[0], rdy1[0], rv[0]}, 3'b001);
    end
    tick();
    rr = 1'b1;
    @(negedge clk);
    chk("t4_hs_cycle", 0, {rdy0[0], rdy1[0], rv[0]}, 3'b001);
    @(negedge clk);
    chk("t4_idle_grant", 0, {(rdy0[0] | rdy1[0]), rv[0]}, 2'b10);
    tick();
    v0 = 1'b0; v1 = 1'b0;
    wait_idle("t4");

    // Randomised traffic with random backpressure
    for (int k = 0; k < 700; k++) begin
      tick();
      v0 = ($urandom_range(0, 99) < 60);
      v1 = ($urandom_range(0, 99) < 60);
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      rr = ($urandom_range(0, 99) < 70);
    end
    tick();
    v0 = 1'b0; v1 = 1'b0; rr = 1'b1;
    wait_idle("rnd");

    // Reset in the middle of an operation
    tick();
    v0 = 1'b1; v1 = 1'b1; a0 = 32'h3F800000; b0 = 32'h3F800000;
    wait_grant0("t5");
    tick();
    chk("t5_pre_busy", 0, bsy[0], 1);
    reset = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("t5_busy", i, bsy[i], 0);
      chk("t5_rv", i, rv[i], 0);
      chk("t5_cnt", i, {cnt0[i], cnt1[i]}, 0);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    v0 = 1'b1; v1 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("t5_first_win", i, {rdy0[i], rdy1[i]}, 2'b10);
    tick();
    v0 = 1'b0; v1 = 1'b0;
    wait_idle("t5");
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
